// File: rtl/fsr_pkg.sv
// Shared types and default constants for the FSR press decoder.
package fsr_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam int          SAMPLE_W_DEF       = 12;
    localparam int          AVG_LOG2_DEF       = 4;
    localparam int          SETTLE_SAMPLES_DEF = 2;
    localparam int          DEBOUNCE_DEF       = 3;
    localparam logic [11:0] THRESH_ON_DEF      = 12'h800;
    localparam logic [11:0] THRESH_OFF_DEF     = 12'h600;

endpackage

// File: rtl/fsr_press_decoder_side.sv
// Per-side decision logic: level register, hysteresis compare, debounce and events.
module fsr_side_debounce #(
    parameter int                  SAMPLE_W   = 12,
    parameter logic [SAMPLE_W-1:0] THRESH_ON  = 12'h800,
    parameter logic [SAMPLE_W-1:0] THRESH_OFF = 12'h600,
    parameter int                  DEBOUNCE   = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                decide_i,
    input  logic [SAMPLE_W-1:0] avg_i,
    output logic [SAMPLE_W-1:0] level_o,
    output logic                pressed_o,
    output logic                press_evt_o,
    output logic                release_evt_o
);

    localparam int            DB_W    = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic [SAMPLE_W-1:0] level_q, level_d;
    logic [DB_W-1:0]     cnt_q, cnt_d;
    logic                pressed_q, pressed_d;
    logic                press_evt_q, press_evt_d;
    logic                release_evt_q, release_evt_d;
    logic                raw;

    // The threshold depends on the current debounced state, giving hysteresis.
    assign raw = avg_i >= (pressed_q ? THRESH_OFF : THRESH_ON);

    always_comb begin
        level_d       = level_q;
        cnt_d         = cnt_q;
        pressed_d     = pressed_q;
        press_evt_d   = 1'b0;
        release_evt_d = 1'b0;
        if (decide_i) begin
            level_d = avg_i;
            if (raw == pressed_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
                pressed_d     = raw;
                press_evt_d   = raw;
                release_evt_d = ~raw;
                cnt_d         = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            level_q       <= '0;
            cnt_q         <= '0;
            pressed_q     <= 1'b0;
            press_evt_q   <= 1'b0;
            release_evt_q <= 1'b0;
        end else begin
            level_q       <= level_d;
            cnt_q         <= cnt_d;
            pressed_q     <= pressed_d;
            press_evt_q   <= press_evt_d;
            release_evt_q <= release_evt_d;
        end
    end

    assign level_o       = level_q;
    assign pressed_o     = pressed_q;
    assign press_evt_o   = press_evt_q;
    assign release_evt_o = release_evt_q;

endmodule

// File: rtl/fsr_press_decoder.sv
// Slot tracking, settle/accumulate FSM and routing of slot averages to each side.
module fsr_press_decoder
    import fsr_pkg::*;
#(
    parameter int                  SAMPLE_W       = 12,
    parameter int                  AVG_LOG2       = 4,
    parameter int                  SETTLE_SAMPLES = 2,
    parameter logic [SAMPLE_W-1:0] THRESH_ON      = 12'h800,
    parameter logic [SAMPLE_W-1:0] THRESH_OFF     = 12'h600,
    parameter int                  DEBOUNCE       = 3
) (
    input  logic                CLK100MHZ,
    input  logic                RST_BTN_N,
    input  logic                direction_cs,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                left_pressed,
    output logic                right_pressed,
    output logic                both_pressed,
    output logic                left_press_evt,
    output logic                right_press_evt,
    output logic                left_release_evt,
    output logic                right_release_evt,
    output logic [SAMPLE_W-1:0] left_level,
    output logic [SAMPLE_W-1:0] right_level
);

    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    localparam int SET_W = $clog2(SETTLE_SAMPLES + 1);
    localparam int CNT_W = (AVG_LOG2 + 1 > SET_W) ? AVG_LOG2 + 1 : SET_W;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] ACC_LAST    = CNT_W'((1 << AVG_LOG2) - 1);

    state_e              state_q, state_d;
    logic                dir_q;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                both_q;
    logic                slot_change;
    logic                decide;
    logic [SAMPLE_W-1:0] avg;

    assign slot_change = direction_cs != dir_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        decide  = 1'b0;
        // A slot change overrides everything, including a sample in the same cycle.
        if (slot_change) begin
            state_d = SETTLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SETTLE: if (sample_valid) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ACCUM: if (sample_valid) begin
                    acc_d = acc_q + ACC_W'(sample);
                    if (cnt_q == ACC_LAST) begin
                        cnt_d   = '0;
                        state_d = DECIDE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DECIDE: begin
                    decide  = 1'b1;
                    state_d = DONE;
                end
                DONE:    state_d = DONE;
                default: state_d = SETTLE;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!RST_BTN_N) begin
            state_q <= SETTLE;
            dir_q   <= CH_LEFT;
            acc_q   <= '0;
            cnt_q   <= '0;
            both_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= direction_cs;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            both_q  <= left_pressed & right_pressed;
        end
    end

    assign avg = SAMPLE_W'(acc_q >> AVG_LOG2);

    fsr_side_debounce #(
        .SAMPLE_W  (SAMPLE_W),
        .THRESH_ON (THRESH_ON),
        .THRESH_OFF(THRESH_OFF),
        .DEBOUNCE  (DEBOUNCE)
    ) u_left (
        .clk_i        (CLK100MHZ),
        .rst_ni       (RST_BTN_N),
        .decide_i     (decide && (dir_q == CH_LEFT)),
        .avg_i        (avg),
        .level_o      (left_level),
        .pressed_o    (left_pressed),
        .press_evt_o  (left_press_evt),
        .release_evt_o(left_release_evt)
    );

    fsr_side_debounce #(
        .SAMPLE_W  (SAMPLE_W),
        .THRESH_ON (THRESH_ON),
        .THRESH_OFF(THRESH_OFF),
        .DEBOUNCE  (DEBOUNCE)
    ) u_right (
        .clk_i        (CLK100MHZ),
        .rst_ni       (RST_BTN_N),
        .decide_i     (decide && (dir_q == CH_RIGHT)),
        .avg_i        (avg),
        .level_o      (right_level),
        .pressed_o    (right_pressed),
        .press_evt_o  (right_press_evt),
        .release_evt_o(right_release_evt)
    );

    assign both_pressed = both_q;

endmodule

// File: tb/tb_fsr_press_decoder.sv
// Randomized bench for fsr_press_decoder against a slot-level behavioural model.
module tb_fsr_press_decoder;

    localparam int          SW   = 12;
    localparam int          AL   = 4;
    localparam int          SET  = 2;
    localparam int          DEB  = 3;
    localparam int          NACC = 1 << AL;
    localparam logic [11:0] ON   = 12'h800;
    localparam logic [11:0] OFF  = 12'h600;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          direction_cs;
    logic          sample_valid;
    logic [SW-1:0] sample;
    logic          left_pressed, right_pressed, both_pressed;
    logic          left_press_evt, right_press_evt, left_release_evt, right_release_evt;
    logic [SW-1:0] left_level, right_level;

    always #5 clk = ~clk;

    fsr_press_decoder dut (
        .CLK100MHZ        (clk),
        .RST_BTN_N        (rst_n),
        .direction_cs     (direction_cs),
        .sample_valid     (sample_valid),
        .sample           (sample),
        .left_pressed     (left_pressed),
        .right_pressed    (right_pressed),
        .both_pressed     (both_pressed),
        .left_press_evt   (left_press_evt),
        .right_press_evt  (right_press_evt),
        .left_release_evt (left_release_evt),
        .right_release_evt(right_release_evt),
        .left_level       (left_level),
        .right_level      (right_level)
    );

    wire [30:0] obs = {left_pressed, right_pressed, both_pressed, left_press_evt, left_release_evt,
                       right_press_evt, right_release_evt, left_level, right_level};

    int total = 0;
    int bad   = 0;

    // Model state per side: index 0 = left, 1 = right.
    bit          m_pr[2];
    int          m_cnt[2];
    logic [11:0] m_lvl[2];
    bit          m_pe[2];
    bit          m_re[2];
    bit          dir_cur;

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_pr[s] = 0; m_cnt[s] = 0; m_lvl[s] = '0; m_pe[s] = 0; m_re[s] = 0;
        end
    endtask

    task automatic model_decide(input bit s, input logic [11:0] avg);
        bit raw;
        for (int k = 0; k < 2; k++) begin m_pe[k] = 0; m_re[k] = 0; end
        m_lvl[s] = avg;
        raw = m_pr[s] ? (avg >= OFF) : (avg >= ON);
        if (raw == m_pr[s]) begin
            m_cnt[s] = 0;
        end else begin
            m_cnt[s] = m_cnt[s] + 1;
            if (m_cnt[s] == DEB) begin
                m_pr[s]  = raw;
                m_pe[s]  = raw;
                m_re[s]  = !raw;
                m_cnt[s] = 0;
            end
        end
    endtask

    function automatic logic [30:0] exp_vec(input bit both, input bit pl, input bit rl,
                                            input bit pr, input bit rr);
        return {m_pr[0], m_pr[1], both, pl, rl, pr, rr, m_lvl[0], m_lvl[1]};
    endfunction

    task automatic gap();
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            sample_valid = 1'b0;
            sample       = 12'($urandom);
        end
    endtask

    // One slot for a side: optional toggle-away, slot change with a junk sample,
    // settle samples, then n_acc accumulated samples; full slots are checked
    // the cycle before, at and after the outputs update.
    task automatic run_slot(input string tag, input bit side, input logic [11:0] base,
                            input int spread, input int n_acc, input logic [11:0] settle_val,
                            input bit rand_settle);
        logic [30:0] e;
        logic [11:0] v;
        int          sum;
        bit          old_both;
        if (dir_cur == side) begin
            @(negedge clk);
            direction_cs = ~side; sample_valid = 1'b1; sample = 12'hFFF;
        end
        @(negedge clk);
        direction_cs = side; sample_valid = 1'b1; sample = 12'hFFF;
        dir_cur = side;
        for (int i = 0; i < SET; i++) begin
            gap();
            @(negedge clk);
            sample_valid = 1'b1;
            sample       = rand_settle ? 12'($urandom) : settle_val;
        end
        sum = 0;
        for (int i = 0; i < n_acc; i++) begin
            gap();
            v = base + 12'($urandom_range(0, spread));
            @(negedge clk);
            sample_valid = 1'b1; sample = v;
            sum += int'(v);
        end
        if (n_acc == NACC) begin
            @(posedge clk); #1;
            total++;
            e = exp_vec(m_pr[0] & m_pr[1], 0, 0, 0, 0);
            if (obs !== e) begin bad++; $display("FAIL %s_pre: got %h expected %h", tag, obs, e); end
            old_both = m_pr[0] & m_pr[1];
            model_decide(side, 12'(sum >> AL));
            @(negedge clk);
            sample_valid = 1'b0;
            @(posedge clk); #1;
            total++;
            e = exp_vec(old_both, m_pe[0], m_re[0], m_pe[1], m_re[1]);
            if (obs !== e) begin bad++; $display("FAIL %s_dec: got %h expected %h", tag, obs, e); end
            @(posedge clk); #1;
            total++;
            e = exp_vec(m_pr[0] & m_pr[1], 0, 0, 0, 0);
            if (obs !== e) begin bad++; $display("FAIL %s_post: got %h expected %h", tag, obs, e); end
        end else begin
            @(negedge clk);
            sample_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            total++;
            e = exp_vec(m_pr[0] & m_pr[1], 0, 0, 0, 0);
            if (obs !== e) begin bad++; $display("FAIL %s_trunc: got %h expected %h", tag, obs, e); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; direction_cs = 1'b0; sample_valid = 1'b1; sample = 12'hABC;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs !== 31'd0) begin bad++; $display("FAIL reset: got %h expected 0", obs); end
        @(negedge clk);
        rst_n = 1'b1; sample_valid = 1'b0;
        model_reset();
        dir_cur = 1'b0;
    endtask

    task automatic test_left_press();
        for (int i = 0; i < 3; i++) run_slot("left_press", 1'b0, 12'h900, 0, NACC, 12'h000, 1);
        total++;
        if (left_pressed !== 1'b1 || left_level !== 12'h900) begin
            bad++; $display("FAIL left_press_final: got %b/%h expected 1/900", left_pressed, left_level);
        end
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 5; i++) run_slot("hyst_hold", 1'b0, 12'h700, 0, NACC, 12'h000, 1);
        for (int i = 0; i < 3; i++) run_slot("hyst_rel", 1'b0, 12'h500, 0, NACC, 12'h000, 1);
        total++;
        if (left_pressed !== 1'b0) begin bad++; $display("FAIL hyst_final: got %b expected 0", left_pressed); end
    endtask

    task automatic test_debounce_reset();
        logic [11:0] vals[6] = '{12'h900, 12'h900, 12'h100, 12'h900, 12'h900, 12'h900};
        for (int i = 0; i < 5; i++) run_slot("deb_reset", 1'b1, vals[i], 0, NACC, 12'h000, 1);
        total++;
        if (right_pressed !== 1'b0) begin bad++; $display("FAIL deb_nopress: got %b expected 0", right_pressed); end
        run_slot("deb_sixth", 1'b1, vals[5], 0, NACC, 12'h000, 1);
        total++;
        if (right_pressed !== 1'b1) begin bad++; $display("FAIL deb_press: got %b expected 1", right_pressed); end
    endtask

    task automatic test_settle_discard();
        for (int i = 0; i < 4; i++) run_slot("settle", 1'b0, 12'h100, 0, NACC, 12'hFFF, 0);
        total++;
        if (left_level !== 12'h100 || left_pressed !== 1'b0) begin
            bad++; $display("FAIL settle_final: got %h/%b expected 100/0", left_level, left_pressed);
        end
    endtask

    task automatic test_truncated();
        run_slot("trunc_a", 1'b0, 12'h900, 0, NACC, 12'h000, 1);
        run_slot("trunc_b", 1'b0, 12'h900, 0, NACC, 12'h000, 1);
        run_slot("trunc_cut", 1'b0, 12'hC00, 0, 10, 12'h000, 1);
        run_slot("trunc_c", 1'b0, 12'h900, 0, NACC, 12'h000, 1);
        total++;
        if (left_pressed !== 1'b1) begin bad++; $display("FAIL trunc_press: got %b expected 1", left_pressed); end
    endtask

    task automatic test_reset_mid_both();
        run_slot("mid_cut", 1'b0, 12'h900, 0, 8, 12'h000, 1);
        @(negedge clk);
        rst_n = 1'b0; direction_cs = 1'b0; sample_valid = 1'b1; sample = 12'h900;
        @(posedge clk); #1;
        total++;
        if (obs !== 31'd0) begin bad++; $display("FAIL reset_mid: got %h expected 0", obs); end
        @(negedge clk);
        rst_n = 1'b1; sample_valid = 1'b0;
        model_reset();
        dir_cur = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_slot("both_l", 1'b0, 12'h900, 0, NACC, 12'h000, 1);
            run_slot("both_r", 1'b1, 12'hA00, 0, NACC, 12'h000, 1);
        end
        total++;
        if (both_pressed !== 1'b1) begin bad++; $display("FAIL both_final: got %b expected 1", both_pressed); end
    endtask

    task automatic test_random();
        logic [11:0] bases[5] = '{12'h100, 12'h500, 12'h700, 12'h900, 12'hE00};
        int          n;
        for (int i = 0; i < 30; i++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NACC - 1)) : NACC;
            run_slot("random", 1'($urandom), bases[$urandom_range(0, 4)], 255, n, 12'h000, 1);
        end
    endtask

    initial begin
        test_reset();
        test_left_press();
        test_hysteresis();
        test_debounce_reset();
        test_settle_discard();
        test_truncated();
        test_reset_mid_both();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
